// File: rtl/fft_inplace_sched.sv
// Control sequencer for an in-place radix-2 DIF FFT over two parity-mapped SRAM banks.
// Optional inverse-transform support via `define FFT_IFFT_EN (adds inverse / tw_conj ports).
module fft_inplace_sched #(
    parameter int LOG2N    = 5,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             valid,
    output logic             busy,
    output logic             input_done,
    output logic             bank_select,
    output logic             swap0_en,
    output logic             swap1_en,
    output logic             we_b0,
    output logic             re_b0,
    output logic             we_b1,
    output logic             re_b1,
    output logic [LOG2N-2:0] raddr_b0,
    output logic [LOG2N-2:0] raddr_b1,
    output logic [LOG2N-2:0] waddr_b0,
    output logic [LOG2N-2:0] waddr_b1,
    output logic [LOG2N-2:0] tw_idx,
    output logic             output_start,
    output logic             done
`ifdef FFT_IFFT_EN
    ,
    input  logic             inverse,
    output logic             tw_conj
`endif
);

    localparam int AW   = LOG2N - 1;
    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(LOG2N + 1);
    localparam int DW   = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic parity_f(input logic [LOG2N-1:0] x);
        return ^x;
    endfunction

    state_t            state_r, state_nxt;
    logic [LOG2N-1:0]  cnt_r, cnt_nxt;
    logic [SW-1:0]     stage_r, stage_nxt;
    logic [DW-1:0]     dcnt_r, dcnt_nxt;
    logic              done_r, done_nxt;

    logic [LOG2N-1:0]  h_s, mask_s, o_s, u_s;
    logic [AW-1:0]     la_s, ra0_s, ra1_s, tw_s;
    logic              par_s;
    logic [AW-1:0]     ra0_hold_r, ra1_hold_r, tw_hold_r;
    logic              par_hold_r;
    logic [AW-1:0]     ra0_rs, ra1_rs, tw_rs;
    logic              par_rs;
    logic              rd_s, adv_s, last_s;

    logic [PIPE_LAT-1:0] wv_pipe_r;
    logic [PIPE_LAT-1:0] sw1_pipe_r;
    logic [AW-1:0]       wa0_pipe_r [PIPE_LAT];
    logic [AW-1:0]       wa1_pipe_r [PIPE_LAT];
    logic [AW-1:0]       tw_pipe_r  [PIPE_LAT-1];
    logic                sw0_r;

    // Butterfly address generation: u = (j/h)*2h + (j mod h), l = u + h.
    always_comb begin
        h_s    = LOG2N'(HALF >> stage_r);
        mask_s = h_s - LOG2N'(1);
        o_s    = cnt_r & mask_s;
        u_s    = ((cnt_r & ~mask_s) << 1) | o_s;
        la_s   = u_s[LOG2N-1:1] | h_s[LOG2N-1:1];
        par_s  = parity_f(u_s);
        tw_s   = AW'(o_s << stage_r);
        if (par_s) begin
            ra0_s = la_s;
            ra1_s = u_s[LOG2N-1:1];
        end else begin
            ra0_s = u_s[LOG2N-1:1];
            ra1_s = la_s;
        end
    end

    assign rd_s   = (state_r == ST_READ);
    assign adv_s  = valid && ((state_r == ST_READ) || (state_r == ST_DRAIN));
    assign last_s = (stage_r == SW'(LOG2N - 1));

    // Read-side values hold their last issued butterfly outside READ.
    always_comb begin
        if (rd_s) begin
            ra0_rs = ra0_s;
            ra1_rs = ra1_s;
            tw_rs  = tw_s;
            par_rs = par_s;
        end else begin
            ra0_rs = ra0_hold_r;
            ra1_rs = ra1_hold_r;
            tw_rs  = tw_hold_r;
            par_rs = par_hold_r;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        stage_nxt = stage_r;
        dcnt_nxt  = dcnt_r;
        done_nxt  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                    dcnt_nxt  = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (valid) begin
                    if (cnt_r == LOG2N'(N - 1)) begin
                        state_nxt = ST_READ;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + LOG2N'(1);
                    end
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_READ: begin
                if (valid) begin
                    if (cnt_r == LOG2N'(HALF - 1)) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = '0;
                        dcnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_r + LOG2N'(1);
                    end
                end else begin
                    state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (valid) begin
                    if (dcnt_r == DW'(PIPE_LAT - 1)) begin
                        dcnt_nxt = '0;
                        if (last_s) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_READ;
                            stage_nxt = stage_r + SW'(1);
                        end
                    end else begin
                        dcnt_nxt = dcnt_r + DW'(1);
                    end
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and end-of-frame pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            stage_r <= '0;
            dcnt_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            stage_r <= stage_nxt;
            dcnt_r  <= dcnt_nxt;
            done_r  <= done_nxt;
        end
    end

    // Delay lines from read issue to swap, twiddle and write-back.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ra0_hold_r <= '0;
            ra1_hold_r <= '0;
            tw_hold_r  <= '0;
            par_hold_r <= 1'b0;
            sw0_r      <= 1'b0;
            wv_pipe_r  <= '0;
            sw1_pipe_r <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                wa0_pipe_r[i] <= '0;
                wa1_pipe_r[i] <= '0;
            end
            for (int i = 0; i < PIPE_LAT - 1; i++) begin
                tw_pipe_r[i] <= '0;
            end
        end else if (adv_s) begin
            ra0_hold_r    <= ra0_rs;
            ra1_hold_r    <= ra1_rs;
            tw_hold_r     <= tw_rs;
            par_hold_r    <= par_rs;
            sw0_r         <= par_rs;
            wv_pipe_r     <= {wv_pipe_r[PIPE_LAT-2:0], rd_s};
            sw1_pipe_r    <= {sw1_pipe_r[PIPE_LAT-2:0], par_rs};
            wa0_pipe_r[0] <= ra0_rs;
            wa1_pipe_r[0] <= ra1_rs;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wa0_pipe_r[i] <= wa0_pipe_r[i-1];
                wa1_pipe_r[i] <= wa1_pipe_r[i-1];
            end
            tw_pipe_r[0] <= tw_rs;
            for (int i = 1; i < PIPE_LAT - 1; i++) begin
                tw_pipe_r[i] <= tw_pipe_r[i-1];
            end
        end else begin
            sw0_r <= sw0_r;
        end
    end

`ifdef FFT_IFFT_EN
    logic tw_conj_r;

    // Transform direction latched per frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tw_conj_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            tw_conj_r <= inverse;
        end else if (done_r) begin
            tw_conj_r <= 1'b0;
        end else begin
            tw_conj_r <= tw_conj_r;
        end
    end

    assign tw_conj = tw_conj_r;
`endif

    // Strobes are qualified by valid so a stall never touches the banks.
    always_comb begin
        busy         = (state_r != ST_IDLE);
        input_done   = (state_r == ST_READ) || (state_r == ST_DRAIN);
        bank_select  = 1'b0;
        we_b0        = 1'b0;
        we_b1        = 1'b0;
        re_b0        = valid && rd_s;
        re_b1        = valid && rd_s;
        raddr_b0     = ra0_rs;
        raddr_b1     = ra1_rs;
        waddr_b0     = wa0_pipe_r[PIPE_LAT-1];
        waddr_b1     = wa1_pipe_r[PIPE_LAT-1];
        swap0_en     = sw0_r;
        swap1_en     = sw1_pipe_r[PIPE_LAT-1];
        tw_idx       = tw_pipe_r[PIPE_LAT-2];
        output_start = 1'b0;
        done         = done_r;
        if (state_r == ST_LOAD) begin
            bank_select = parity_f(cnt_r);
            we_b0       = valid && !parity_f(cnt_r);
            we_b1       = valid && parity_f(cnt_r);
            waddr_b0    = cnt_r[LOG2N-1:1];
            waddr_b1    = cnt_r[LOG2N-1:1];
        end else if (input_done) begin
            we_b0        = valid && wv_pipe_r[PIPE_LAT-1] && !last_s;
            we_b1        = valid && wv_pipe_r[PIPE_LAT-1] && !last_s;
            output_start = valid && wv_pipe_r[PIPE_LAT-1] && last_s;
        end else begin
            bank_select = 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_inplace_sched.sv
// Directed bench for fft_inplace_sched (N=32, PIPE_LAT=2): table vectors per frame
// plus frame-level timing checks for stall, ignored start and mid-frame reset.
module tb_fft_inplace_sched;

    localparam int LOG2N = 5;
    localparam int PL    = 2;
    localparam int AW    = LOG2N - 1;

    localparam int S_WE0 = 0,  S_WE1 = 1,  S_RE0 = 2,  S_RE1 = 3;
    localparam int S_RA0 = 4,  S_RA1 = 5,  S_WA0 = 6,  S_WA1 = 7;
    localparam int S_SW0 = 8,  S_SW1 = 9,  S_TW  = 10, S_IDN = 11;
    localparam int S_BSL = 12, S_OS  = 13, S_DN  = 14, S_BSY = 15;
    localparam int NSIG  = 16;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic busy, input_done, bank_select, swap0_en, swap1_en;
    logic we_b0, re_b0, we_b1, re_b1, output_start, done;
    logic [AW-1:0] raddr_b0, raddr_b1, waddr_b0, waddr_b1, tw_idx;
`ifdef FFT_IFFT_EN
    logic inverse = 1'b0;
    logic tw_conj;
`endif

    fft_inplace_sched #(.LOG2N(LOG2N), .PIPE_LAT(PL)) dut (
        .clk(clk), .nrst(nrst), .start(start), .valid(valid),
        .busy(busy), .input_done(input_done), .bank_select(bank_select),
        .swap0_en(swap0_en), .swap1_en(swap1_en),
        .we_b0(we_b0), .re_b0(re_b0), .we_b1(we_b1), .re_b1(re_b1),
        .raddr_b0(raddr_b0), .raddr_b1(raddr_b1),
        .waddr_b0(waddr_b0), .waddr_b1(waddr_b1),
        .tw_idx(tw_idx), .output_start(output_start), .done(done)
`ifdef FFT_IFFT_EN
        , .inverse(inverse), .tw_conj(tw_conj)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    frame;
        int    cyc;
        int    sig;
        int    exp;
        string name;
    } vec_t;

    vec_t tbl[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int get_sig(input int id);
        case (id)
            S_WE0: return int'(we_b0);
            S_WE1: return int'(we_b1);
            S_RE0: return int'(re_b0);
            S_RE1: return int'(re_b1);
            S_RA0: return int'(raddr_b0);
            S_RA1: return int'(raddr_b1);
            S_WA0: return int'(waddr_b0);
            S_WA1: return int'(waddr_b1);
            S_SW0: return int'(swap0_en);
            S_SW1: return int'(swap1_en);
            S_TW:  return int'(tw_idx);
            S_IDN: return int'(input_done);
            S_BSL: return int'(bank_select);
            S_OS:  return int'(output_start);
            S_DN:  return int'(done);
            S_BSY: return int'(busy);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int f, input int c, input int s, input int e, input string n);
        vec_t v;
        v.frame = f; v.cyc = c; v.sig = s; v.exp = e; v.name = n;
        tbl.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < NSIG; i++) begin
            chk($sformatf("%s_sig%0d", tag, i), get_sig(i), 0);
        end
    endtask

    // Runs one frame; start is sampled at edge 0 and cycle c follows edge c-1.
    task automatic run_frame(input int fid, input int stall_lo, input int stall_hi,
                             input int abort_c, output int done_c, output int done_cnt,
                             output int os_first, output int os_last, output int os_cnt);
        bit stop;
        stop = 1'b0;
        done_c = -1; done_cnt = 0; os_first = -1; os_last = -1; os_cnt = 0;
        start = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 150 && !stop; c++) begin
            start = (fid == 0) && (c == 10 || c == 80);
            valid = !(c >= stall_lo && c <= stall_hi);
            #1;
            foreach (tbl[i]) begin
                if (tbl[i].frame == fid && tbl[i].cyc == c)
                    chk($sformatf("f%0d_c%0d_%s", fid, c, tbl[i].name), get_sig(tbl[i].sig), tbl[i].exp);
            end
            if (output_start) begin
                if (os_first < 0) os_first = c;
                os_last = c;
                os_cnt++;
            end
            if (done) begin
                if (done_c < 0) done_c = c;
                done_cnt++;
            end
            if (c == abort_c) begin
                nrst = 1'b0;
                #1;
                chk_all_zero($sformatf("abort_c%0d", c));
                @(posedge clk);
                #1;
                chk_all_zero("abort_held");
                nrst = 1'b1;
                stop = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        valid = 1'b1;
    endtask

    int dc, dn, of, ol, oc;

    initial begin
        // frame 0: no stalls, spurious starts at cycles 10 and 80
        add(0,   4, S_WE0, 1, "load_k3_we0");
        add(0,   4, S_WE1, 0, "load_k3_we1");
        add(0,   4, S_WA0, 1, "load_k3_waddr0");
        add(0,   4, S_BSL, 0, "load_k3_bsel");
        add(0,   4, S_IDN, 0, "load_input_done");
        add(0,   4, S_BSY, 1, "load_busy");
        add(0,   8, S_WE1, 1, "load_k7_we1");
        add(0,   8, S_WE0, 0, "load_k7_we0");
        add(0,   8, S_WA1, 3, "load_k7_waddr1");
        add(0,   8, S_BSL, 1, "load_k7_bsel");
        add(0,  32, S_RE0, 0, "load_last_re0");
        add(0,  33, S_RE0, 1, "s0_first_re0");
        add(0,  35, S_SW0, 1, "s0_j1_swap0");
        add(0,  36, S_RA0, 1, "s0_j3_raddr0");
        add(0,  36, S_RA1, 9, "s0_j3_raddr1");
        add(0,  36, S_RE1, 1, "s0_j3_re1");
        add(0,  36, S_IDN, 1, "s0_input_done");
        add(0,  37, S_SW0, 0, "s0_j3_swap0");
        add(0,  37, S_TW,  3, "s0_j3_tw");
        add(0,  37, S_SW1, 1, "s0_j2_swap1");
        add(0,  38, S_SW1, 0, "s0_j3_swap1");
        add(0,  38, S_WE0, 1, "s0_j3_we0");
        add(0,  38, S_WE1, 1, "s0_j3_we1");
        add(0,  38, S_WA0, 1, "s0_j3_waddr0");
        add(0,  38, S_WA1, 9, "s0_j3_waddr1");
        add(0,  49, S_RE0, 0, "s0_drain_re0");
        add(0,  49, S_WE0, 1, "s0_drain_we0");
        add(0,  51, S_RE0, 1, "s1_first_re0");
        add(0,  51, S_WE0, 0, "s1_first_we0");
        add(0,  60, S_RA0, 8, "s1_j9_raddr0");
        add(0,  60, S_RA1, 12, "s1_j9_raddr1");
        add(0,  61, S_TW,  2, "s1_j9_tw");
        add(0,  61, S_SW0, 0, "s1_j9_swap0");
        add(0, 107, S_OS,  1, "s4_first_out");
        add(0, 107, S_WE0, 0, "s4_no_write");
        add(0, 110, S_TW,  0, "s4_tw");
        add(0, 123, S_DN,  1, "done");
        add(0, 123, S_BSY, 0, "done_busy");
        add(0, 123, S_IDN, 0, "done_input_done");
        // frame 1: valid low for cycles 72..76 inside READ(2)
        add(1,  72, S_RE0, 0, "stall_re0");
        add(1,  72, S_WE0, 0, "stall_we0");
        add(1,  72, S_RA0, 1, "stall_raddr0");
        add(1,  72, S_RA1, 3, "stall_raddr1");
        add(1,  75, S_TW,  8, "stall_tw");
        add(1,  76, S_RE1, 0, "stall_re1");
        add(1,  76, S_RA0, 1, "stall_hold_raddr0");
        add(1,  77, S_RE0, 1, "resume_re0");
        add(1,  77, S_WE0, 1, "resume_we0");
        add(1,  77, S_WA0, 2, "resume_waddr0");
        add(1,  78, S_RA0, 6, "resume_j4_raddr0");
        add(1,  78, S_RA1, 4, "resume_j4_raddr1");
        // frame 2: reset mid-frame
        add(2,  36, S_RA1, 9, "pre_abort_raddr1");
        // frame 3: fresh frame after abort
        add(3,   4, S_WE0, 1, "fresh_load_we0");

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);

        run_frame(0, -1, -1, -1, dc, dn, of, ol, oc);
        chk("f0_done_cycle", dc, 123);
        chk("f0_done_count", dn, 1);
        chk("f0_out_first", of, 107);
        chk("f0_out_last", ol, 122);
        chk("f0_out_count", oc, 16);

        run_frame(1, 72, 76, -1, dc, dn, of, ol, oc);
        chk("f1_done_cycle", dc, 128);
        chk("f1_done_count", dn, 1);
        chk("f1_out_first", of, 112);
        chk("f1_out_last", ol, 127);
        chk("f1_out_count", oc, 16);

        run_frame(2, -1, -1, 60, dc, dn, of, ol, oc);
        chk("f2_no_done", dn, 0);
        @(posedge clk);
        #1;

        run_frame(3, -1, -1, -1, dc, dn, of, ol, oc);
        chk("f3_done_cycle", dc, 123);
        chk("f3_out_count", oc, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
